// File: rtl/mem_stage_lsu_if.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu_if
// Data-memory bus between the MEM-stage load/store unit and data memory.
//
// Signals:
//   dmem_req    LSU -> mem  request, held until dmem_ready
//   dmem_we     LSU -> mem  1 = write, 0 = read
//   dmem_addr   LSU -> mem  word address, bits [1:0] always 0
//   dmem_wdata  LSU -> mem  lane-replicated store data
//   dmem_be     LSU -> mem  byte enables
//   dmem_ready  mem -> LSU  request completes this cycle
//   dmem_rdata  mem -> LSU  read word, valid together with dmem_ready
//
// Modports: master (the LSU), slave (the memory), monitor (observe only).
// -----------------------------------------------------------------------------
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ready,
    output dmem_rdata
  );

  modport monitor (
    input dmem_req,
    input dmem_we,
    input dmem_addr,
    input dmem_wdata,
    input dmem_be,
    input dmem_ready,
    input dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Load/store unit for the MEM stage of a 5-stage RV32I pipeline. Converts the
// EX/MEM load/store controls into one data-memory bus transaction, stalls the
// pipeline while the bus inserts wait states, and returns aligned and
// sign/zero-extended load data for the MEM/WB register.
//
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles without dmem_ready before the access aborts
//                   with a fault (1..65535)
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   ex_mem_valid_i         instruction in MEM is valid
//   ex_mem_mem_read_i      load
//   ex_mem_mem_write_i     store
//   ex_mem_funct3_i        RV32I load/store funct3 (size/sign)
//   ex_mem_alu_result_i    effective byte address
//   ex_mem_rs2_data_i      store source data
//   dmem                   data-memory bus (master side)
//   mem_read_data_o        formatted load result to MEM/WB
//   mem_stall_o            freeze the front of the pipe, bubble MEM/WB
//   mem_access_fault_o     one-cycle pulse on a rejected or timed-out access
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ex_mem_valid_i,
  input  logic                   ex_mem_mem_read_i,
  input  logic                   ex_mem_mem_write_i,
  input  logic [2:0]             ex_mem_funct3_i,
  input  logic [31:0]            ex_mem_alu_result_i,
  input  logic [31:0]            ex_mem_rs2_data_i,
  mem_stage_lsu_if.master        dmem,
  output logic [31:0]            mem_read_data_o,
  output logic                   mem_stall_o,
  output logic                   mem_access_fault_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter value seen in the last REQ cycle before the access is abandoned.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  // ---------------------------------------------------------------------------
  // Formatting helpers
  // ---------------------------------------------------------------------------

  // funct3 values the ISA defines for the given direction.
  function automatic logic f3_legal(input logic is_read, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = is_read;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] access_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicating across lanes lets memory pick the bytes with be alone.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{rs2[7:0]}};
      2'b01:   wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{byte_v[7]}}, byte_v};
      3'b001:  res = {{16{half_v[15]}}, half_v};
      3'b010:  res = word;
      3'b100:  res = {24'h000000, byte_v};
      3'b101:  res = {16'h0000, half_v};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tfault_q, tfault_d;

  logic        access_s;
  logic        bad_s;
  logic        stall_s;
  logic        afault_s;

  // Request decode; only meaningful while the FSM is waiting in IDLE.
  always_comb begin
    access_s = ex_mem_valid_i & (ex_mem_mem_read_i | ex_mem_mem_write_i);
    bad_s    = (ex_mem_mem_read_i & ex_mem_mem_write_i)
             | ~f3_legal(ex_mem_mem_read_i, ex_mem_funct3_i)
             | misaligned(ex_mem_funct3_i, ex_mem_alu_result_i[1:0]);
  end

  // Next-state and combinational outputs of the access FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    tfault_d = 1'b0;
    stall_s  = 1'b0;
    afault_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          if (bad_s) begin
            // Rejected before touching the bus; pipeline keeps moving.
            afault_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            addr_d  = {ex_mem_alu_result_i[31:2], 2'b00};
            we_d    = ex_mem_mem_write_i;
            be_d    = access_be(ex_mem_funct3_i, ex_mem_alu_result_i[1:0]);
            wdata_d = store_wdata(ex_mem_funct3_i, ex_mem_rs2_data_i);
            f3_d    = ex_mem_funct3_i;
            off_d   = ex_mem_alu_result_i[1:0];
            cnt_d   = 16'd0;
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        stall_s = 1'b1;
        if (dmem.dmem_ready) begin
          if (!we_q) begin
            rdata_d = load_format(f3_q, off_q, dmem.dmem_rdata);
          end else begin
            rdata_d = rdata_q;
          end
          cnt_d   = 16'd0;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Fault pulse and zeroed load data appear together in DONE.
          tfault_d = 1'b1;
          rdata_d  = 32'h0000_0000;
          cnt_d    = 16'd0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        // One unstalled cycle; the EX/MEM inputs are still the finished
        // instruction, so they must not start a second access.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched transaction registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 16'd0;
      addr_q   <= 32'h0000_0000;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      wdata_q  <= 32'h0000_0000;
      f3_q     <= 3'b000;
      off_q    <= 2'b00;
      rdata_q  <= 32'h0000_0000;
      tfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      tfault_q <= tfault_d;
    end
  end

  assign dmem.dmem_req   = (state_q == ST_REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign mem_read_data_o = rdata_q;
  // Gated by rstn so stall and fault drop the instant reset asserts, even
  // while EX/MEM still presents an access.
  assign mem_stall_o        = stall_s & rstn;
  assign mem_access_fault_o = (afault_s | tfault_q) & rstn;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_read, ex_write;
  logic [2:0]  ex_f3;
  logic [31:0] ex_addr, ex_rs2;
  logic [31:0] mem_rd;
  logic        mem_stall, mem_fault;
  bit          mon_off = 1'b1;

  always #5 clk = ~clk;

  mem_stage_lsu_if bus();

  mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .ex_mem_valid_i     (ex_valid),
    .ex_mem_mem_read_i  (ex_read),
    .ex_mem_mem_write_i (ex_write),
    .ex_mem_funct3_i    (ex_f3),
    .ex_mem_alu_result_i(ex_addr),
    .ex_mem_rs2_data_i  (ex_rs2),
    .dmem               (bus),
    .mem_read_data_o    (mem_rd),
    .mem_stall_o        (mem_stall),
    .mem_access_fault_o (mem_fault)
  );

  typedef struct {
    bit          imm;      // rejected immediately, no bus access
    bit          fault;
    logic [31:0] rd;
    int          stall;
    int          reqc;
    bit          we;
    logic [31:0] addr;
    bit          chk_be;
    logic [3:0]  be;
    bit          chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  logic [31:0] last_rd = 32'd0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model + driver for one EX/MEM instruction and its memory reply.
  task automatic issue(input bit v, input bit r, input bit w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2,
                       input int waits, input logic [31:0] word);
    exp_t        e;
    int          size, off, reqn;
    bit          legal, bad, done, to;
    logic [31:0] sh;
    if (v && (r || w)) begin
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off   = int'(a[1:0]);
      legal = r ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
      bad   = (r && w) || !legal || ((off % size) != 0);
      e = '{default: 0};
      if (bad) begin
        e.imm = 1'b1;
        e.rd  = last_rd;
      end else begin
        to      = (waits >= T);
        e.reqc  = to ? T : waits + 1;
        e.stall = 1 + e.reqc;
        e.fault = to;
        e.we    = w;
        e.addr  = a & 32'hFFFF_FFFC;
        for (int k = 0; k < 4; k++) e.be[k] = (k >= off) && (k < off + size);
        e.chk_be = w || (f3 == 3'd2);
        e.chk_wd = w;
        e.wd = (size == 1) ? {4{rs2[7:0]}} : (size == 2) ? {2{rs2[15:0]}} : rs2;
        sh = word >> (8 * off);
        if (to)      e.rd = 32'd0;
        else if (w)  e.rd = last_rd;
        else case (f3)
          3'd0:    e.rd = int'($signed(sh[7:0]));
          3'd1:    e.rd = int'($signed(sh[15:0]));
          3'd4:    e.rd = {24'd0, sh[7:0]};
          3'd5:    e.rd = {16'd0, sh[15:0]};
          default: e.rd = word;
        endcase
      end
      last_rd = e.rd;
      q.push_back(e);
    end
    ex_valid = v; ex_read = r; ex_write = w; ex_f3 = f3; ex_addr = a; ex_rs2 = rs2;
    reqn = 0;
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (bus.dmem_req) begin
        bus.dmem_ready = (reqn == waits);
        bus.dmem_rdata = (reqn == waits) ? word : $urandom;
        reqn++;
        if ($urandom_range(0, 3) == 0) ex_valid = 1'b0;
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
      end
      #1;
      if (!mem_stall) done = 1'b1;
      @(negedge clk);
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL instr_budget: stall still 1 after 64 cycles, required 0");
    end
  endtask

  // Monitor: samples just before each rising edge and scores completions.
  initial begin
    bit          prev_st;
    int          stc, rqc;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    logic        we0;
    exp_t        e;
    prev_st = 1'b0; stc = 0; rqc = 0;
    a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rstn || mon_off) begin
        prev_st = 1'b0; stc = 0; rqc = 0;
      end else begin
        if (bus.dmem_req) begin
          if (rqc == 0) begin
            a0 = bus.dmem_addr; w0 = bus.dmem_wdata; b0 = bus.dmem_be; we0 = bus.dmem_we;
          end else begin
            chk("req_fields_stable",
                32'((bus.dmem_addr == a0) && (bus.dmem_wdata == w0) &&
                    (bus.dmem_be == b0) && (bus.dmem_we == we0)), 32'd1);
          end
          rqc++;
        end
        if (mem_stall) stc++;
        if (prev_st && !mem_stall) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_done: got completion, required none");
          end else begin
            e = q.pop_front();
            chk("kind_access", 32'(e.imm), 32'd0);
            chk("stall_cycles", stc, e.stall);
            chk("req_cycles", rqc, e.reqc);
            chk("done_fault", 32'(mem_fault), 32'(e.fault));
            chk("done_req_low", 32'(bus.dmem_req), 32'd0);
            chk("read_data", mem_rd, e.rd);
            chk("dmem_we", 32'(we0), 32'(e.we));
            chk("dmem_addr", a0, e.addr);
            if (e.chk_be) chk("dmem_be", 32'(b0), 32'(e.be));
            if (e.chk_wd) chk("dmem_wdata", w0, e.wd);
          end
          stc = 0; rqc = 0;
        end else if (!prev_st && mem_fault) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_fault: got fault pulse, required none");
          end else begin
            e = q.pop_front();
            chk("kind_reject", 32'(e.imm), 32'd1);
            chk("reject_req", 32'(bus.dmem_req), 32'd0);
            chk("reject_read_data", mem_rd, e.rd);
          end
        end else if (mem_fault) begin
          n_chk++; n_fail++;
          $display("FAIL fault_while_stalled: got fault=1 during stall, required 0");
        end
        prev_st = mem_stall;
      end
    end
  end

  initial begin
    int          k;
    bit          v, r, w;
    logic [2:0]  f3;
    logic [31:0] a;
    rstn = 1'b0;
    ex_valid = 1'b0; ex_read = 1'b0; ex_write = 1'b0; ex_f3 = 3'd0; ex_addr = 32'd0; ex_rs2 = 32'd0;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = 32'd0;
    @(negedge clk); #1;
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_read_data", mem_rd, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_be", 32'(bus.dmem_be), 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    mon_off = 1'b0;

    // Directed cases
    issue(1, 1, 0, 3'd2, 32'h0000_1004, 32'd0, 0, 32'hDEAD_BEEF);   // LW
    issue(1, 1, 0, 3'd0, 32'h0000_1003, 32'd0, 0, 32'h80FF_0000);   // LB
    issue(1, 1, 0, 3'd4, 32'h0000_1003, 32'd0, 1, 32'h80FF_0000);   // LBU
    issue(1, 0, 1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 3, 32'd0);   // SH, 3 waits
    issue(1, 1, 0, 3'd2, 32'h0000_1002, 32'd0, 0, 32'd0);           // misaligned LW
    issue(1, 1, 0, 3'd5, 32'h0000_1002, 32'd0, 2, 32'h8765_4321);   // LHU upper half
    issue(1, 1, 0, 3'd2, 32'h0000_1008, 32'd0, 50, 32'h1111_1111);  // timeout
    issue(1, 1, 1, 3'd2, 32'h0000_1000, 32'd0, 0, 32'd0);           // read & write
    issue(1, 0, 1, 3'd4, 32'h0000_1000, 32'd0, 0, 32'd0);           // illegal store f3

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 19);
      v = (k != 0);
      r = (k < 10) || (k == 17) || (k == 18);
      w = ((k >= 10) && (k < 17)) || (k == 17) || (k == 18);
      if (k == 19) begin r = 1'b0; w = 1'b0; end
      if ($urandom_range(0, 4) != 0) begin
        k = $urandom_range(0, 4);
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      issue(v, r, w, f3, a, $urandom, $urandom_range(0, 5), $urandom);
    end

    // Reset in the middle of a bus request
    mon_off = 1'b1;
    ex_valid = 1'b1; ex_read = 1'b1; ex_write = 1'b0; ex_f3 = 3'd2; ex_addr = 32'h0000_3000;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(bus.dmem_req), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.dmem_req), 32'd0);
    chk("midrst_stall", 32'(mem_stall), 32'd0);
    chk("midrst_fault", 32'(mem_fault), 32'd0);
    chk("midrst_read_data", mem_rd, 32'd0);
    chk("midrst_addr", bus.dmem_addr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    ex_valid = 1'b0;
    @(negedge clk);
    last_rd = 32'd0;
    mon_off = 1'b0;
    issue(1, 1, 0, 3'd2, 32'h0000_3008, 32'd0, 1, 32'hCAFE_F00D);
    issue(1, 1, 0, 3'd1, 32'h0000_300E, 32'd0, 0, 32'h9ABC_0000);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
